// File: rtl/fadd_arbiter.sv
// fadd_arbiter: two-requester round-robin front end for one shared half-precision adder.
//
// Ports
//   clk, reset            single clock, synchronous active-high reset
//   req_valid/req_ready   per-requester request handshake (ready is one-hot or zero)
//   req_add, req_A, req_B per-requester operation flag and operands, 16 bits per requester
//   fa_add, fa_A, fa_B    registered operands driven to the shared adder
//   fa_Result, fa_OverFlow, fa_UnderFlow  adder outputs, sampled once per operation
//   resp_valid/resp_ready per-requester response handshake (valid is one-hot or zero)
//   resp_Result, resp_OverFlow, resp_UnderFlow  captured adder outputs
//   busy                  high whenever an operation is outstanding
//
// Only one operation is in flight. Operands are held on the adder for SETTLE_CYCLES
// cycles, then the adder outputs are captured and offered to the granted requester.

module fadd_arbiter #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [1:0]  req_add,
  input  logic [31:0] req_A,
  input  logic [31:0] req_B,
  output logic        fa_add,
  output logic [15:0] fa_A,
  output logic [15:0] fa_B,
  input  logic [15:0] fa_Result,
  input  logic        fa_OverFlow,
  input  logic        fa_UnderFlow,
  output logic [1:0]  resp_valid,
  input  logic [1:0]  resp_ready,
  output logic [15:0] resp_Result,
  output logic        resp_OverFlow,
  output logic        resp_UnderFlow,
  output logic        busy
);

  localparam logic [3:0] SettleInit = 4'(SETTLE_CYCLES);

  typedef enum logic [1:0] {StIdle, StSettle, StResp} state_e;

  state_e      state_q, state_d;
  logic        ptr_q, ptr_d;
  logic        gnt_q, gnt_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        op_add_q, op_add_d;
  logic [15:0] op_a_q, op_a_d;
  logic [15:0] op_b_q, op_b_d;
  logic [15:0] res_q, res_d;
  logic        ovf_q, ovf_d;
  logic        udf_q, udf_d;

  logic [1:0]  grant;
  logic        grant_idx;

  // Grant is only offered in IDLE and never while reset is asserted.
  always_comb begin
    grant = 2'b00;
    if (!reset && state_q == StIdle) begin
      unique case (req_valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = ptr_q ? 2'b10 : 2'b01;
        default: grant = 2'b00;
      endcase
    end
  end

  assign grant_idx = grant[1];
  assign req_ready = grant;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gnt_d    = gnt_q;
    cnt_d    = cnt_q;
    op_add_d = op_add_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    res_d    = res_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;

    unique case (state_q)
      StIdle: begin
        if (grant != 2'b00) begin
          gnt_d    = grant_idx;
          ptr_d    = ~grant_idx;
          op_add_d = req_add[grant_idx];
          op_a_d   = grant_idx ? req_A[31:16] : req_A[15:0];
          op_b_d   = grant_idx ? req_B[31:16] : req_B[15:0];
          cnt_d    = SettleInit;
          state_d  = StSettle;
        end
      end
      StSettle: begin
        // Counter holds the number of settle cycles left including this one.
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          res_d   = fa_Result;
          ovf_d   = fa_OverFlow;
          udf_d   = fa_UnderFlow;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        if (resp_ready[gnt_q]) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      ptr_q    <= 1'b0;
      gnt_q    <= 1'b0;
      cnt_q    <= 4'd0;
      op_add_q <= 1'b0;
      op_a_q   <= 16'h0000;
      op_b_q   <= 16'h0000;
      res_q    <= 16'h0000;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
      cnt_q    <= cnt_d;
      op_add_q <= op_add_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      res_q    <= res_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  assign fa_add         = op_add_q;
  assign fa_A           = op_a_q;
  assign fa_B           = op_b_q;
  assign resp_Result    = res_q;
  assign resp_OverFlow  = ovf_q;
  assign resp_UnderFlow = udf_q;
  assign resp_valid     = (state_q == StResp) ? (gnt_q ? 2'b10 : 2'b01) : 2'b00;
  assign busy           = (state_q != StIdle);

endmodule

// File: doc/fadd_arbiter.md
FADD_ARBITER -- requirements
Module: fadd_arbiter

Interface
REQ-001 Parameter SETTLE_CYCLES, default 1, sets the number of cycles operands are held on the shared adder before its result is captured; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req_valid  input  2  bit i: requester i has an operation pending.
REQ-005 req_ready  output  2  bit i: requester i is accepted this cycle (one-hot or zero).
REQ-006 req_add  input  2  bit i: requester i operation flag, passed unchanged to fa_add.
REQ-007 req_A  input  32  operand A; [15:0] requester 0, [31:16] requester 1; each half is {Sign, Exponent[5], Mantissa[10]}.
REQ-008 req_B  input  32  operand B, same packing as req_A.
REQ-009 fa_add  output  1  operation flag to the shared FAdder_HalfPrecision.
REQ-010 fa_A  output  16  operand 1 to the shared adder, {Sign, Exponent, Mantissa}.
REQ-011 fa_B  output  16  operand 2 to the shared adder, same packing.
REQ-012 fa_Result  input  16  adder result {out_Sign, out_Exponent, out_Mantissa}.
REQ-013 fa_OverFlow  input  1  adder output-overflow flag.
REQ-014 fa_UnderFlow  input  1  adder exponent-underflow flag.
REQ-015 resp_valid  output  2  bit i: result for requester i is valid (one-hot or zero).
REQ-016 resp_ready  input  2  bit i: requester i consumes its result.
REQ-017 resp_Result  output  16  captured result.
REQ-018 resp_OverFlow  output  1  captured overflow flag.
REQ-019 resp_UnderFlow  output  1  captured underflow flag.
REQ-020 busy  output  1  high whenever the state is not IDLE.

Function
REQ-021 The FSM SHALL have the states IDLE, SETTLE and RESP; only one operation is outstanding at a time.
REQ-022 In IDLE, if exactly one req_valid bit is set, that requester SHALL be granted; if both are set, requester ptr SHALL be granted (1-bit round-robin pointer).
REQ-023 req_ready SHALL be combinational and equal the one-hot grant while in IDLE; it SHALL be 2'b00 in every other state.
REQ-024 In the handshake cycle C, the granted requester's req_add, req_A and req_B SHALL be registered, gnt SHALL be recorded, ptr SHALL be set to ~gnt, and the state SHALL go to SETTLE.
REQ-025 fa_add, fa_A and fa_B SHALL be driven from the operand registers only; they change only on acceptance and hold their value otherwise, IDLE included.
REQ-026 SETTLE SHALL last exactly SETTLE_CYCLES cycles (C+1 .. C+SETTLE_CYCLES), using a 4-bit down-counter.
REQ-027 On the last SETTLE cycle, fa_Result, fa_OverFlow and fa_UnderFlow SHALL be registered into the resp_* registers and the state SHALL go to RESP; adder outputs are ignored at all other times.
REQ-028 In RESP, resp_valid[gnt] SHALL be 1 from cycle C+SETTLE_CYCLES+1 with resp_* held stable until resp_ready[gnt]=1, after which the next state is IDLE.
REQ-029 resp_ready on the non-granted bit, or in any state other than RESP, SHALL have no effect.
REQ-030 resp_ready asserted in the first RESP cycle SHALL complete the response in that cycle, so the minimum issue interval is SETTLE_CYCLES+2 cycles.
REQ-031 A requester dropping req_valid before its handshake SHALL not be granted; no pending state is kept for non-granted requesters.
REQ-032 Overflow and underflow flags SHALL be forwarded unmodified; the block performs no arithmetic on the operands or results.

Reset
REQ-033 Reset SHALL force state IDLE, ptr=0, counter=0, and zero all operand and result registers, so that fa_add=0, fa_A=fa_B=0, resp_*=0, resp_valid=2'b00 and busy=0.
REQ-034 Reset asserted mid-SETTLE or mid-RESP SHALL discard the operation; no resp_valid follows it.
REQ-035 While reset is high, req_ready SHALL be 2'b00 regardless of req_valid.

Verification
REQ-036 SETTLE_CYCLES=1, req_valid=01, req_A[15:0]=req_B[15:0]=16'h3C00, req_add=01 at cycle C -> req_ready=01 at C; fa_A=fa_B=16'h3C00 and fa_add=1 from C+1; resp_valid=01 at C+2 with resp_Result=16'h4000 (real adder).
REQ-037 After reset, req_valid=11 held continuously with resp_ready=11 -> grants in order r0, r1, r0, r1; each grant is 3 cycles after the previous one.
REQ-038 resp_ready=00 for 5 cycles during RESP -> resp_valid and resp_Result stay constant, req_ready=00 and busy=1 throughout; completion occurs on the cycle resp_ready[gnt]=1.
REQ-039 SETTLE_CYCLES=3, single accept at C -> resp_valid at C+4; fa_Result changed at C+4 does not alter resp_Result.
REQ-040 reset pulsed at C+1 after an accept -> at C+2 all outputs are 0, and resp_valid stays 00 until a new request is accepted.
